// File: rtl/pipe_pkg.sv
// Shared types and screen constants for the pipe field and its helpers.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pipe_pkg;

    localparam int COORD_W  = 11;
    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

    typedef logic [COORD_W-1:0] coord_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        OVER = 2'd2
    } state_t;

endpackage

// File: rtl/lfsr8.sv
// 8-bit Fibonacci LFSR (taps 8,6,5,4) used to pick pipe gap heights.
// Latency: value advances one step per enabled clock.
// Backpressure: none; enable simply freezes the sequence.
module lfsr8 (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    output logic [7:0] value
);

    // Shift left, feeding back the XOR of taps 8,6,5,4; seed is nonzero so the sequence never locks up.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            value <= 8'hA5;
        end else if (enable) begin
            value <= {value[6:0], value[7] ^ value[5] ^ value[4] ^ value[3]};
        end
    end

endmodule

// File: rtl/pipe_field.sv
// Owns the game run state, scrolls two pipes leftward per frame_tick, picks gaps and flags bird/pipe and bird/floor hits.
// Latency: all outputs registered; a hit sampled on one edge shows as collision after that edge.
// Backpressure: none; restart/frame_tick pulses are consumed on arrival. Build option FIXED_GAP_EN: wrapping pipes reload GAP_DEFAULT and no LFSR exists.
module pipe_field
    import pipe_pkg::*;
#(
    parameter int PIPE_W       = 40,
    parameter int PIPE_SPACING = 320,
    parameter int GAP_H        = 120,
    parameter int GAP_MIN      = 60,
    parameter int GAP_DEFAULT  = 180,
    parameter int BIRD_W       = 16,
    parameter int BIRD_H       = 16,
    parameter int SPEED        = 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               restart,
    input  logic               frame_tick,
    input  logic [COORD_W-1:0] bird_x,
    input  logic [COORD_W-1:0] bird_y,
    output logic [COORD_W-1:0] pipe1_x,
    output logic [COORD_W-1:0] pipe2_x,
    output logic [COORD_W-1:0] pipe1_gap,
    output logic [COORD_W-1:0] pipe2_gap,
    output logic               collision,
    output logic               running
);

    // One extra bit so edge/sum comparisons never wrap near 2047.
    typedef logic [COORD_W:0] wide_t;

    localparam coord_t SPAWN1_X      = coord_t'(SCREEN_W);
    localparam coord_t SPAWN2_X      = coord_t'(SCREEN_W + PIPE_SPACING);
    localparam coord_t SPEED_C       = coord_t'(SPEED);
    localparam coord_t WRAP_ADD      = coord_t'(2 * PIPE_SPACING - SPEED);
    localparam coord_t GAP_DEFAULT_C = coord_t'(GAP_DEFAULT);

    state_t state;
    coord_t wrap_gap;
    logic   floor_hit;
    logic   any_hit;

    // Bird box overlaps the pipe columns and is not fully inside the opening.
    function automatic logic pipe_hit(input coord_t px, input coord_t gap,
                                      input coord_t bx, input coord_t by);
        logic h_overlap;
        logic v_miss;
        h_overlap = (wide_t'(bx) + wide_t'(BIRD_W) > wide_t'(px)) &&
                    (wide_t'(bx) < wide_t'(px) + wide_t'(PIPE_W));
        v_miss    = (wide_t'(by) < wide_t'(gap)) ||
                    (wide_t'(by) + wide_t'(BIRD_H) > wide_t'(gap) + wide_t'(GAP_H));
        return h_overlap && v_miss;
    endfunction

    // A pipe that cannot step left any more reappears one full spacing pair to the right.
    function automatic coord_t scroll_x(input coord_t px);
        return (px >= SPEED_C) ? coord_t'(px - SPEED_C) : coord_t'(px + WRAP_ADD);
    endfunction

`ifdef FIXED_GAP_EN
    assign wrap_gap = GAP_DEFAULT_C;
`else
    logic [7:0] lfsr_val;

    lfsr8 u_lfsr (
        .clock  (clock),
        .reset  (reset),
        .enable (state == RUN),
        .value  (lfsr_val)
    );

    // Low 7 LFSR bits offset from the minimum gives gap_top in GAP_MIN..GAP_MIN+127.
    assign wrap_gap = coord_t'(GAP_MIN) + coord_t'(lfsr_val & 8'h7F);
`endif

    assign floor_hit = (wide_t'(bird_y) + wide_t'(BIRD_H) >= wide_t'(SCREEN_H));
    assign any_hit   = floor_hit ||
                       pipe_hit(pipe1_x, pipe1_gap, bird_x, bird_y) ||
                       pipe_hit(pipe2_x, pipe2_gap, bird_x, bird_y);

    // Run-state machine with pipe scrolling; restart outranks frame_tick, and a hit still lets that cycle's scroll land.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            pipe1_x   <= SPAWN1_X;
            pipe2_x   <= SPAWN2_X;
            pipe1_gap <= GAP_DEFAULT_C;
            pipe2_gap <= GAP_DEFAULT_C;
            collision <= 1'b0;
            running   <= 1'b0;
        end else if (restart) begin
            state     <= RUN;
            pipe1_x   <= SPAWN1_X;
            pipe2_x   <= SPAWN2_X;
            pipe1_gap <= GAP_DEFAULT_C;
            pipe2_gap <= GAP_DEFAULT_C;
            collision <= 1'b0;
            running   <= 1'b1;
        end else if (state == RUN) begin
            if (frame_tick) begin
                pipe1_x <= scroll_x(pipe1_x);
                pipe2_x <= scroll_x(pipe2_x);
                if (pipe1_x < SPEED_C) begin
                    pipe1_gap <= wrap_gap;
                end
                if (pipe2_x < SPEED_C) begin
                    pipe2_gap <= wrap_gap;
                end
            end
            if (any_hit) begin
                state     <= OVER;
                collision <= 1'b1;
                running   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pipe_field.sv
// Self-checking bench for pipe_field: directed scenarios plus randomized traffic against a cycle reference model.
// Latency: compares every output 1ns after each rising edge.
// Backpressure: n/a.
module tb_pipe_field;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        restart = 1'b0;
    logic        frame_tick = 1'b0;
    logic [10:0] bird_x = 11'd100;
    logic [10:0] bird_y = 11'd200;
    logic [10:0] pipe1_x, pipe2_x, pipe1_gap, pipe2_gap;
    logic        collision, running;

    always #5 clock = ~clock;

    pipe_field dut (
        .clock      (clock),
        .reset      (reset),
        .restart    (restart),
        .frame_tick (frame_tick),
        .bird_x     (bird_x),
        .bird_y     (bird_y),
        .pipe1_x    (pipe1_x),
        .pipe2_x    (pipe2_x),
        .pipe1_gap  (pipe1_gap),
        .pipe2_gap  (pipe2_gap),
        .collision  (collision),
        .running    (running)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: 0 = idle, 1 = running, 2 = game over.
    int       m_state, m_p1, m_p2, m_g1, m_g2;
    bit [7:0] m_lfsr;
    bit       m_wrapped;
    int       m_gaps[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0;
        m_p1 = 640;
        m_p2 = 960;
        m_g1 = 180;
        m_g2 = 180;
        m_lfsr = 8'hA5;
    endtask

    function automatic bit m_pipe_hit(input int px, input int g);
        int bx = int'(bird_x);
        int by = int'(bird_y);
        return (bx + 16 > px) && (bx < px + 40) && ((by < g) || (by + 16 > g + 120));
    endfunction

    task automatic advance(inout int px, inout int g, input bit [7:0] lf);
        if (px >= 1) begin
            px = px - 1;
        end else begin
            px = px + 640 - 1;
`ifdef FIXED_GAP_EN
            g = 180;
`else
            g = 60 + int'(lf[6:0]);
`endif
            m_wrapped = 1'b1;
            m_gaps.push_back(g);
        end
    endtask

    task automatic model_edge();
        bit [7:0] lf_now = m_lfsr;
        bit       hit;
        m_wrapped = 1'b0;
        if (!reset) begin
            model_reset();
            return;
        end
        if (m_state == 1) m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
        if (restart) begin
            m_state = 1;
            m_p1 = 640;
            m_p2 = 960;
            m_g1 = 180;
            m_g2 = 180;
            return;
        end
        if (m_state == 1) begin
            hit = m_pipe_hit(m_p1, m_g1) || m_pipe_hit(m_p2, m_g2) || (int'(bird_y) + 16 >= 480);
            if (frame_tick) begin
                advance(m_p1, m_g1, lf_now);
                advance(m_p2, m_g2, lf_now);
            end
            if (hit) m_state = 2;
        end
    endtask

    task automatic check_all();
        check("pipe1_x", 32'(pipe1_x), m_p1);
        check("pipe2_x", 32'(pipe2_x), m_p2);
        check("pipe1_gap", 32'(pipe1_gap), m_g1);
        check("pipe2_gap", 32'(pipe2_gap), m_g2);
        check("running", 32'(running), 32'(m_state == 1));
        check("collision", 32'(collision), 32'(m_state == 2));
        if (m_wrapped) begin
            check("gap1_range", 32'(pipe1_gap >= 60 && pipe1_gap <= 187), 1);
            check("gap2_range", 32'(pipe2_gap >= 60 && pipe2_gap <= 187), 1);
        end
    endtask

    task automatic tick_cycle(input bit ft, input bit rs);
        @(negedge clock);
        frame_tick = ft;
        restart    = rs;
        @(posedge clock);
        model_edge();
        #1;
        check_all();
    endtask

    // Changes reset between edges so its assertion is seen asynchronously.
    task automatic set_reset(input bit v);
        @(negedge clock);
        frame_tick = 1'b0;
        restart    = 1'b0;
        #2;
        reset = v;
        #1;
        if (!v) begin
            model_reset();
            check_all();
        end
    endtask

    initial begin
        int       pass100;
        bit       saw_coll;
        int       ticks;
        bit       tpat[$];
        int       run1_gaps[$];
        int       dut_gaps[$];
        logic [10:0] prev1, prev2;

        model_reset();
        // Reset state
        tick_cycle(1'b0, 1'b0);
        tick_cycle(1'b1, 1'b0);
        set_reset(1'b1);

        // Async reset mid-run with pipe1 at 200, then idle holds through ticks
        bird_x = 11'd100;
        bird_y = 11'd200;
        tick_cycle(1'b0, 1'b1);
        repeat (440) tick_cycle(1'b1, 1'b0);
        check("p1_at_200", 32'(pipe1_x), 200);
        set_reset(1'b0);
        check("async_p1", 32'(pipe1_x), 640);
        check("async_p2", 32'(pipe2_x), 960);
        tick_cycle(1'b1, 1'b0);
        set_reset(1'b1);
        repeat (10) tick_cycle(1'b1, 1'b0);
        check("idle_p1_hold", 32'(pipe1_x), 640);
        check("idle_running", 32'(running), 0);

        // Full lap: pass bird once, wrap 0 -> 639 with pipe2 at 319, no collision
        pass100 = 0;
        saw_coll = 1'b0;
        tick_cycle(1'b0, 1'b1);
        repeat (641) begin
            tick_cycle(1'b1, 1'b0);
            if (pipe1_x == 11'd100) pass100++;
            if (collision) saw_coll = 1'b1;
        end
        check("p1_pass100_once", pass100, 1);
        check("wrap_p1", 32'(pipe1_x), 639);
        check("wrap_p2", 32'(pipe2_x), 319);
        check("lap_no_coll", 32'(saw_coll), 0);

        // Pipe edge hit: no overlap at x=116, overlap at 115, then frozen
        tick_cycle(1'b0, 1'b1);
        repeat (524) tick_cycle(1'b1, 1'b0);
        check("p1_at_116", 32'(pipe1_x), 116);
        bird_y = 11'd100;
        tick_cycle(1'b1, 1'b0);
        check("no_hit_at_116", 32'(collision), 0);
        tick_cycle(1'b0, 1'b0);
        check("pipe_hit_coll", 32'(collision), 1);
        check("pipe_hit_run", 32'(running), 0);
        repeat (5) tick_cycle(1'b1, 1'b0);
        check("over_frozen", 32'(pipe1_x), 115);

        // Floor: 463 is safe, 464 hits; restart clears
        bird_x = 11'd1900;
        bird_y = 11'd463;
        tick_cycle(1'b0, 1'b1);
        repeat (3) tick_cycle(1'b1, 1'b0);
        check("floor_463_safe", 32'(collision), 0);
        bird_y = 11'd464;
        tick_cycle(1'b0, 1'b0);
        check("floor_464_hit", 32'(collision), 1);
        bird_y = 11'd200;
        tick_cycle(1'b0, 1'b1);
        check("restart_clr", 32'(collision), 0);
        check("restart_p1", 32'(pipe1_x), 640);
        check("restart_p2", 32'(pipe2_x), 960);

        // restart beats a same-cycle frame_tick
        repeat (3) tick_cycle(1'b1, 1'b0);
        tick_cycle(1'b1, 1'b1);
        check("rs_ft_p1", 32'(pipe1_x), 640);
        check("rs_ft_run", 32'(running), 1);

        // 2000 ticks with random spacing, twice from reset: gap sequence must repeat
        ticks = 0;
        while (ticks < 2000) begin
            bit b = ($urandom_range(0, 3) != 0);
            tpat.push_back(b);
            if (b) ticks++;
        end
        bird_x = 11'd1900;
        bird_y = 11'd200;
        set_reset(1'b0);
        set_reset(1'b1);
        m_gaps.delete();
        tick_cycle(1'b0, 1'b1);
        foreach (tpat[i]) tick_cycle(tpat[i], 1'b0);
        run1_gaps = m_gaps;

        set_reset(1'b0);
        set_reset(1'b1);
        tick_cycle(1'b0, 1'b1);
        prev1 = pipe1_x;
        prev2 = pipe2_x;
        foreach (tpat[i]) begin
            tick_cycle(tpat[i], 1'b0);
            if (pipe1_x > prev1) dut_gaps.push_back(int'(pipe1_gap));
            if (pipe2_x > prev2) dut_gaps.push_back(int'(pipe2_gap));
            prev1 = pipe1_x;
            prev2 = pipe2_x;
        end
        check("rep_count", dut_gaps.size(), run1_gaps.size());
        for (int i = 0; i < dut_gaps.size() && i < run1_gaps.size(); i++) begin
            check("rep_gap", dut_gaps[i], run1_gaps[i]);
        end

        // Random bird positions, ticks and restarts
        for (int c = 0; c < 1500; c++) begin
            if ((c % 16) == 0) begin
                bird_x = 11'($urandom_range(0, 700));
                bird_y = 11'($urandom_range(0, 479));
            end
            tick_cycle(1'($urandom_range(0, 1)), ($urandom_range(0, 63) == 0));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
